// File: rtl/q_stream_deframer_if.sv
// Output handshake bundle of the Q-stream deframer: head word, its last-of-frame flag,
// and the valid/ready pair.
interface q_stream_deframer_if #(
  parameter int W = 8
);
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/q_stream_deframer.sv
// Serial deframer for the registered Q bit: hunts for SYNC_PAT, deserialises FRAME_WORDS
// MSB-first words and hands them out through a 2-entry buffer with sticky overflow.
//
//   state  | meaning
//   S_HUNT | collecting fresh bits, waiting for the sync word
//   S_DATA | deserialising the words of the current frame
module q_stream_deframer #(
  parameter int           W           = 8,
  parameter logic [W-1:0] SYNC_PAT    = 8'hA5,
  parameter int           FRAME_WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                q_in,
  input  logic                q_en,
  q_stream_deframer_if.master out_if,
  output logic                in_sync,
  output logic                overflow,
  output logic [7:0]          frame_cnt
);

  localparam int FILL_W = $clog2(W + 1);
  localparam int BIT_W  = $clog2(W);
  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(W);
  localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(W - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(W - 1);
  localparam logic [7:0]        WORD_LAST = 8'(FRAME_WORDS - 1);

  typedef enum logic {S_HUNT, S_DATA} state_t;

  state_t            state_q, state_d;
  logic [W-1:0]      sh_q, sh_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [7:0]        word_q, word_d;
  logic [7:0]        frame_q, frame_d;

  // buffer entries carry {word, last}; head_q feeds the outputs directly
  logic [W:0]        head_q, head_d;
  logic [W:0]        tail_q, tail_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic [W-1:0]      nxt;
  logic              push;
  logic              push_last;
  logic              pop;
  logic [1:0]        cnt_after_pop;

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    fill_d    = fill_q;
    bit_d     = bit_q;
    word_d    = word_q;
    frame_d   = frame_q;
    push      = 1'b0;
    push_last = 1'b0;
    nxt       = {sh_q[W-2:0], q_in};

    if (q_en) begin
      sh_d = nxt;
      case (state_q)
        S_HUNT: begin
          if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
          // fill gate keeps stale bits from the previous frame out of the match
          if (fill_q >= FILL_ARM && nxt == SYNC_PAT) begin
            state_d = S_DATA;
            bit_d   = '0;
            word_d  = '0;
            fill_d  = '0;
          end
        end
        S_DATA: begin
          if (bit_q == BIT_LAST) begin
            push      = 1'b1;
            push_last = (word_q == WORD_LAST);
            bit_d     = '0;
            if (push_last) begin
              frame_d = frame_q + 8'd1;
              state_d = S_HUNT;
              fill_d  = '0;
            end else begin
              word_d = word_q + 8'd1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
        default: state_d = S_HUNT;
      endcase
    end
  end

  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    cnt_d         = cnt_q;
    ovf_d         = ovf_q;
    pop           = (cnt_q != 2'd0) && out_if.out_ready;
    cnt_after_pop = pop ? cnt_q - 2'd1 : cnt_q;

    if (pop && cnt_q == 2'd2) head_d = tail_q;
    cnt_d = cnt_after_pop;

    // pushing into a full buffer is fine as long as the head leaves on the same edge
    if (push) begin
      case (cnt_after_pop)
        2'd0: begin
          head_d = {nxt, push_last};
          cnt_d  = 2'd1;
        end
        2'd1: begin
          tail_d = {nxt, push_last};
          cnt_d  = 2'd2;
        end
        default: ovf_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_HUNT;
      sh_q    <= '0;
      fill_q  <= '0;
      bit_q   <= '0;
      word_q  <= '0;
      frame_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      fill_q  <= fill_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      frame_q <= frame_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_if.out_data  = head_q[W:1];
  assign out_if.out_last  = head_q[0];
  assign out_if.out_valid = (cnt_q != 2'd0);
  assign in_sync          = (state_q == S_DATA);
  assign overflow         = ovf_q;
  assign frame_cnt        = frame_q;

endmodule
